// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on magnitudes, sign fixup at the end, early completion for /0 and overflow.
module muldiv_sequencer #(
    parameter int D_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [2:0]         i_funct3,
    input  logic [D_WIDTH-1:0] i_op_a,
    input  logic [D_WIDTH-1:0] i_op_b,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_done,
    output logic [D_WIDTH-1:0] o_result
);

    localparam int CW = $clog2(D_WIDTH);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [D_WIDTH-1:0] MOST_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_count;
    logic [2:0]             r_op;
    logic                   r_a_neg;
    logic                   r_b_neg;
    logic                   r_raw;
    logic [D_WIDTH-1:0]     r_opnd;
    logic [D_WIDTH-1:0]     r_result;
    logic [2*D_WIDTH-1:0]   r_acc;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [D_WIDTH-1:0] w_mag_a;
    logic [D_WIDTH-1:0] w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_early;
    logic               w_accept;

    assign w_is_div   = i_funct3[2];
    assign w_a_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                        (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    assign w_b_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    assign w_a_neg    = w_a_signed & i_op_a[D_WIDTH-1];
    assign w_b_neg    = w_b_signed & i_op_b[D_WIDTH-1];
    assign w_mag_a    = w_a_neg ? -i_op_a : i_op_a;
    assign w_mag_b    = w_b_neg ? -i_op_b : i_op_b;
    assign w_div_zero = w_is_div && (i_op_b == '0);
    assign w_ovf      = w_is_div && !i_funct3[0] && (i_op_a == MOST_NEG) && (i_op_b == '1);
    assign w_early    = w_div_zero | w_ovf;
    assign w_accept   = (r_state == S_IDLE) && i_start && !i_flush;

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0]   w_addend;
    logic [D_WIDTH:0]     w_mul_sum;
    logic [2*D_WIDTH-1:0] w_mul_step;
    logic [D_WIDTH:0]     w_rem_sh;
    logic [D_WIDTH:0]     w_trial;
    logic [2*D_WIDTH-1:0] w_div_step;

    // Carry out of the add is kept so the shift brings it into the top bit.
    assign w_addend   = r_acc[0] ? r_opnd : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*D_WIDTH-1:D_WIDTH]} + {1'b0, w_addend};
    assign w_mul_step = {w_mul_sum, r_acc[D_WIDTH-1:1]};

    assign w_rem_sh   = r_acc[2*D_WIDTH-1:D_WIDTH-1];
    assign w_trial    = w_rem_sh - {1'b0, r_opnd};
    assign w_div_step = w_trial[D_WIDTH]
                      ? {w_rem_sh[D_WIDTH-1:0], r_acc[D_WIDTH-2:0], 1'b0}
                      : {w_trial[D_WIDTH-1:0],  r_acc[D_WIDTH-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Result selection and sign fixup
    // ------------------------------------------------------------------
    logic [2*D_WIDTH-1:0] w_prod_fix;
    logic [D_WIDTH-1:0]   w_quo;
    logic [D_WIDTH-1:0]   w_rem;
    logic [D_WIDTH-1:0]   w_quo_fix;
    logic [D_WIDTH-1:0]   w_rem_fix;
    logic [D_WIDTH-1:0]   w_final;

    assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    assign w_quo      = r_acc[D_WIDTH-1:0];
    assign w_rem      = r_acc[2*D_WIDTH-1:D_WIDTH];
    // Early-out results are preloaded in final form and bypass the fixup.
    assign w_quo_fix  = (!r_raw && (r_a_neg ^ r_b_neg)) ? -w_quo : w_quo;
    assign w_rem_fix  = (!r_raw && r_a_neg) ? -w_rem : w_rem;

    always_comb begin
        w_final = r_acc[D_WIDTH-1:0];
        unique case (r_op)
            3'd0:                   w_final = r_acc[D_WIDTH-1:0];
            3'd1, 3'd2, 3'd3:       w_final = w_prod_fix[2*D_WIDTH-1:D_WIDTH];
            3'd4, 3'd5:             w_final = w_quo_fix;
            3'd6, 3'd7:             w_final = w_rem_fix;
            default:                w_final = r_acc[D_WIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_next = w_early ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_count == '0) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // FSM: outputs. The result is presented combinationally in DONE so a
    // coincident flush can still suppress it; r_result holds it afterwards.
    always_comb begin
        o_stall  = !i_rst && (w_accept || (r_state == S_BUSY));
        o_done   = (r_state == S_DONE) && !i_flush;
        o_result = o_done ? w_final : r_result;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_raw    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= i_funct3;
                r_a_neg <= w_a_neg;
                r_b_neg <= w_b_neg;
                r_raw   <= w_early;
                if (w_div_zero) begin
                    r_acc <= {i_op_a, {D_WIDTH{1'b1}}};
                end else if (w_ovf) begin
                    r_acc <= {{D_WIDTH{1'b0}}, MOST_NEG};
                end else if (w_is_div) begin
                    r_acc   <= {{D_WIDTH{1'b0}}, w_mag_a};
                    r_opnd  <= w_mag_b;
                    r_count <= CNT_MAX;
                end else begin
                    r_acc   <= {{D_WIDTH{1'b0}}, w_mag_b};
                    r_opnd  <= w_mag_a;
                    r_count <= CNT_MAX;
                end
            end else if ((r_state == S_BUSY) && !i_flush) begin
                r_acc   <= r_op[2] ? w_div_step : w_mul_step;
                r_count <= r_count - CNT_ONE;
            end

            if ((r_state == S_DONE) && !i_flush) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a cycle-countdown
// reference model that computes results with plain 64-bit arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    muldiv_sequencer #(.D_WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_flush  (flush),
        .o_stall  (stall),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of an RV32M operation.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: cycles left until the done cycle (0 = idle), pending and held results.
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_held = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_held = '0;
        end else if (flush) begin
            m_left = 0;
        end else if (m_left == 1) begin
            m_held = m_pend;
            m_left = 0;
        end else if (m_left > 1) begin
            m_left = m_left - 1;
        end else if (start) begin
            m_pend = ref_op(funct3, op_a, op_b);
            m_left = is_early(funct3, op_a, op_b) ? 1 : 33;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic exp_done;
            logic exp_stall;
            exp_done  = (m_left == 1) && !flush && !rst;
            exp_stall = !rst && (((m_left == 0) && start && !flush) || (m_left > 1));
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("done",  {31'b0, done},  {31'b0, exp_done});
            chk("result", result, exp_done ? m_pend : m_held);
        end
    end

    // Issue one op, keep it held until done; returns with start still high
    // so the next call issues back-to-back.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int st);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; flush = 1'b0;
        lat = 0; st = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (stall) st++;
            lat++;
            if (lat > 60) begin
                checks++; errors++;
                $display("FAIL timeout: no done after %0d cycles, required within 33", lat);
                break;
            end
        end
        res = result;
        $display("op f3=%0d a=%08h b=%08h -> result=%08h latency=%0d stall=%0d", f3, a, b, res, lat, st);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] r;
    int          lat;
    int          st;

    initial begin
        rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;

        // Pin the reference model itself.
        chk("ref_mul",   ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("ref_mulh",  ref_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
        chk("ref_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("ref_div",   ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("ref_rem",   ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, st);
        chk("mul_res", r, 32'hFFFF_FFEB);
        chk("mul_lat", 32'(lat), 32'd33);
        chk("mul_stall", 32'(st), 32'd33);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st);
        chk("mulhu_res", r, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st);
        chk("mulh_res", r, 32'h0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        chk("div_res", r, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        chk("rem_res", r, 32'hFFFF_FFFF);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        chk("divu_res", r, 32'h7FFF_FFFC);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, r, lat, st);
        chk("remu_res", r, 32'h1);
        run_op(3'd5, 32'h1234, 32'h0, r, lat, st);
        chk("divz_res", r, 32'hFFFF_FFFF);
        chk("divz_lat", 32'(lat), 32'd1);
        chk("divz_stall", 32'(st), 32'd1);
        run_op(3'd6, 32'h1234, 32'h0, r, lat, st);
        chk("remz_res", r, 32'h0000_1234);
        go_idle();

        // Flush at BUSY iteration 10: no done, result unchanged.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'hDEAD_BEEF; op_b = 32'h1357_9BDF;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1; flush = 1'b1; start = 1'b0;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_stall", {31'b0, stall}, 32'd0);
        chk("flush_keep", result, 32'h0000_1234);
        run_op(3'd0, 32'h0001_2345, 32'h0000_0100, r, lat, st);
        chk("post_flush_res", r, 32'h0123_4500);
        chk("post_flush_lat", 32'(lat), 32'd33);

        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
        chk("ovf_div_res", r, 32'h8000_0000);
        chk("ovf_div_lat", 32'(lat), 32'd1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
        chk("ovf_rem_res", r, 32'h0);
        go_idle();

        // Flush coincident with DONE: done suppressed, result kept.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd55; op_b = 32'd0;
        @(posedge clk); #1;
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("flush_in_done", {31'b0, done}, 32'd0);
        chk("flush_in_done_res", result, 32'h0);
        @(posedge clk); #1; flush = 1'b0;

        // Flush coincident with start in IDLE: no accept.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0;
        @(negedge clk);
        chk("flush_start_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start_idle", {31'b0, stall}, 32'd0);

        // Asynchronous reset mid-divide.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; op_a = 32'h7654_3210; op_b = 32'd3;
        repeat (15) @(posedge clk);
        #6; rst = 1'b1; start = 1'b0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'h0);
        #1; rst = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, r, lat, st);
        chk("divu_100_7", r, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, r, lat, st);
        chk("remu_100_7", r, 32'd2);
        go_idle();

        // Randomized operations, occasionally interrupted by a flush.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 7) == 0) begin
                int w;
                w = $urandom_range(1, 36);
                @(posedge clk); #1;
                start = 1'b1; funct3 = f3; op_a = a; op_b = b;
                repeat (w) @(posedge clk);
                #1; flush = 1'b1; start = 1'b0;
                @(posedge clk); #1; flush = 1'b0;
                $display("flushed op f3=%0d a=%08h b=%08h after %0d cycles", f3, a, b, w);
            end else begin
                run_op(f3, a, b, r, lat, st);
                chk("rand_res", r, ref_op(f3, a, b));
                chk("rand_lat", 32'(lat), is_early(f3, a, b) ? 32'd1 : 32'd33);
                if ($urandom_range(0, 1) == 0) go_idle();
            end
        end
        go_idle();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide sequencer that sits beside the ALU in the execute stage. It accepts one M-extension operation at a time, runs a 32-step shift-add multiply or restoring divide, and holds the core via a stall output until the result is ready. Divide-by-zero and signed-overflow divides complete early. The execute stage muxes the block's result onto the ALU output path in the cycle that `done` is high.

## Interface
- `D_WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: decoded M-extension instruction present in execute (opcode 7'h33, funct7 7'h01).
- `funct3` input 3: operation select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a` input D_WIDTH: rs1 value (dividend or multiplicand).
- `op_b` input D_WIDTH: rs2 value (divisor or multiplier).
- `flush` input 1: abort any in-flight operation (taken branch or jump redirect).
- `stall` output 1: freeze PC and the execute-stage instruction.
- `done` output 1: one-cycle pulse; `result` is valid this cycle.
- `result` output D_WIDTH: operation result, held until the next accept.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `start`=1 and `flush`=0 → latch `funct3` and operands, and convert signed operands to magnitudes with sign flags.
    - DIV/DIVU/REM/REMU with `op_b`=0 → DONE.
    - DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF → DONE.
    - Otherwise → BUSY, with `count` loaded to 31.
  - Operand signedness: MULH signed×signed; MULHSU signed `op_a` × unsigned `op_b`; DIV/REM signed; MUL and all unsigned ops unsigned.
- **BUSY**
  - Each cycle performs one iteration and decrements `count`.
  - Multiply: 64-bit product register, add-then-shift-right by 1.
  - Divide: 64-bit {remainder, quotient} register, shift-left by 1, trial subtract, set quotient bit when the subtraction does not go negative.
  - `count`=0 → DONE.
- **DONE**
  - `result` is written, `done`=1, then → IDLE unconditionally.
  - Result selection:
    - MUL: low 32 bits.
    - MULH/MULHSU/MULHU: high 32 bits, after applying the sign fixup. The product is negated if exactly one operand was signed-negative.
    - DIV/DIVU: quotient, negated if operand signs differ (signed only).
    - REM/REMU: remainder, taking the sign of the dividend (signed only).
  - Divide-by-zero: quotient = 0xFFFFFFFF, remainder = `op_a`.
  - Overflow: quotient = 0x80000000, remainder = 0.
- `stall` = (IDLE & `start` & !`flush`) | BUSY. Combinational and 0 in DONE, so the held instruction retires with `result` in the DONE cycle.
- `start` in BUSY or DONE is ignored. It is the same held instruction; no re-accept happens until IDLE.
- `flush`=1 in any state → IDLE at the next edge. `done` is suppressed and `result` is left unchanged.
- Arithmetic is all modulo 2^64 internally and truncated to 32 bits at the output. No X propagation from unused operand bits.

## Timing
- Reset (async, any state): state=IDLE, `count`=0, `result`=0, `done`=0. `stall`=0 while `rst` is high.
- Normal op: accept at edge E0, BUSY for edges E1..E32, `done`=1 in the cycle after E32. Latency is 33 cycles from the accept edge to the `done` cycle; `stall` is high for 33 cycles.
- Early-out ops (divide-by-zero, overflow): `done`=1 the cycle after the accept edge. `stall` is high for 1 cycle.
- Back-to-back: a new `start` is accepted in the IDLE cycle after DONE. Minimum issue interval is 34 cycles (normal) or 2 cycles (early-out).
- `flush` coincident with `start` in IDLE: no accept, `stall`=0.
- `flush` coincident with the DONE state: `done` is still forced 0 and `result` is not updated.
- `rst` asserted mid-BUSY: immediate return to IDLE. The operation is lost, and `result` is cleared to 0.

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD (−3) → `stall` high 33 cycles, `done` at cycle 33, `result`=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → `result`=0xFFFFFFFE. MULH same operands → `result`=0x00000000.
- DIV 0xFFFFFFF9 (−7) / 2 → `result`=0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU same operands → 0x7FFFFFFC. REMU same operands → 1.
- DIVU 0x1234 / 0 → `done` 1 cycle after accept, `result`=0xFFFFFFFF. REM 0x1234 / 0 → 0x00001234.
- DIV 0x80000000 / 0xFFFFFFFF → 1-cycle `done`, `result`=0x80000000. REM same operands → 0.
- MUL started, then `flush` at BUSY iteration 10 → IDLE next edge, no `done`, `result` keeps its previous value. A new MUL issued immediately after completes normally in 33 cycles.
- `rst` pulsed mid-DIV (not aligned to `clk`) → outputs go to reset values immediately, `stall`=0. A following DIVU 100/7 → `result`=14; REMU 100/7 → 2.
